// File: rtl/maze_mem_arbiter_if.sv
// Bus bundle between the two maze requesters, the arbiter and the maze memory port.
// The master side is the requester/memory environment; the slave side is the arbiter.
interface maze_mem_arbiter_if #(
    parameter int maze_width = 6
);
    logic                  req0;
    logic                  req1;
    logic [maze_width-1:0] row0;
    logic [maze_width-1:0] col0;
    logic [maze_width-1:0] row1;
    logic [maze_width-1:0] col1;
    logic                  oe0;
    logic                  we0;
    logic                  oe1;
    logic                  we1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  rvalid0;
    logic                  rvalid1;
    logic                  rdata0;
    logic                  rdata1;
    logic [maze_width-1:0] mem_row;
    logic [maze_width-1:0] mem_col;
    logic                  mem_oe;
    logic                  mem_we;
    logic                  mem_in;

    modport master (
        output req0, req1, row0, col0, row1, col1, oe0, we0, oe1, we1, mem_in,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               mem_row, mem_col, mem_oe, mem_we
    );

    modport slave (
        input  req0, req1, row0, col0, row1, col1, oe0, we0, oe1, we1, mem_in,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               mem_row, mem_col, mem_oe, mem_we
    );
endinterface

// File: rtl/maze_mem_arbiter.sv
// Burst arbiter sharing the maze memory port between the wall-follower solver (port 0)
// and the host loader/dump engine (port 1), round-robin on ties with optional hold limit.
module maze_mem_arbiter #(
    parameter int maze_width = 6,
    parameter int max_hold   = 0     // 0 = no limit; must fit the 16-bit hold counter
) (
    input  logic               clk,
    input  logic               rst_n,
    maze_mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10,
        TURN = 2'b11
    } state_t;

    localparam logic [maze_width-1:0] CELL_ZERO = '0;
    localparam bit                    HOLD_EN   = (max_hold != 0);
    localparam logic [15:0]           HOLD_LAST = (max_hold == 0) ? 16'd0 : 16'(max_hold - 1);
    localparam logic [15:0]           HOLD_SAT  = 16'hFFFF;

    state_t      state_r;
    state_t      state_s;
    logic        last_owner_r;
    logic        last_owner_s;
    logic [15:0] hold_cnt_r;
    logic [15:0] hold_cnt_s;
    logic        gnt0_r;
    logic        gnt1_r;
    logic        rvalid0_r;
    logic        rvalid1_r;
    logic        pick_valid_s;
    logic        pick_port_s;
    logic        hold_hit_s;
    logic        rd0_s;
    logic        rd1_s;

    // Write wins over read, so a simultaneous oe/we never produces a return
    assign rd0_s      = gnt0_r & bus.oe0 & ~bus.we0;
    assign rd1_s      = gnt1_r & bus.oe1 & ~bus.we1;
    assign hold_hit_s = HOLD_EN && (hold_cnt_r == HOLD_LAST);

    // Round-robin pick among pending requests; ties go to the port that did not own last
    always_comb begin
        pick_valid_s = 1'b0;
        pick_port_s  = 1'b0;
        if (bus.req0 && bus.req1) begin
            pick_valid_s = 1'b1;
            pick_port_s  = ~last_owner_r;
        end else if (bus.req0) begin
            pick_valid_s = 1'b1;
            pick_port_s  = 1'b0;
        end else if (bus.req1) begin
            pick_valid_s = 1'b1;
            pick_port_s  = 1'b1;
        end else begin
            pick_valid_s = 1'b0;
            pick_port_s  = 1'b0;
        end
    end

    // Ownership FSM next state, round-robin history and hold counter
    always_comb begin
        state_s      = state_r;
        last_owner_s = last_owner_r;
        hold_cnt_s   = hold_cnt_r;
        case (state_r)
            IDLE, TURN: begin
                if (pick_valid_s) begin
                    state_s    = pick_port_s ? OWN1 : OWN0;
                    hold_cnt_s = 16'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            OWN0: begin
                if (!bus.req0 || (bus.req1 && hold_hit_s)) begin
                    state_s      = TURN;
                    last_owner_s = 1'b0;
                end else if (bus.req1 && (hold_cnt_r != HOLD_SAT)) begin
                    hold_cnt_s = hold_cnt_r + 16'd1;
                end else begin
                    hold_cnt_s = hold_cnt_r;
                end
            end
            OWN1: begin
                if (!bus.req1 || (bus.req0 && hold_hit_s)) begin
                    state_s      = TURN;
                    last_owner_s = 1'b1;
                end else if (bus.req0 && (hold_cnt_r != HOLD_SAT)) begin
                    hold_cnt_s = hold_cnt_r + 16'd1;
                end else begin
                    hold_cnt_s = hold_cnt_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, grants and read-return tags; grants are decoded from the next state so they stay registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_owner_r <= 1'b1;
            hold_cnt_r   <= 16'd0;
            gnt0_r       <= 1'b0;
            gnt1_r       <= 1'b0;
            rvalid0_r    <= 1'b0;
            rvalid1_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            last_owner_r <= last_owner_s;
            hold_cnt_r   <= hold_cnt_s;
            gnt0_r       <= (state_s == OWN0);
            gnt1_r       <= (state_s == OWN1);
            rvalid0_r    <= rd0_s;
            rvalid1_r    <= rd1_s;
        end
    end

    // Memory port mux: only the granted port reaches the memory
    always_comb begin
        bus.mem_row = CELL_ZERO;
        bus.mem_col = CELL_ZERO;
        bus.mem_we  = 1'b0;
        if (gnt0_r) begin
            bus.mem_row = bus.row0;
            bus.mem_col = bus.col0;
            bus.mem_we  = bus.we0;
        end else if (gnt1_r) begin
            bus.mem_row = bus.row1;
            bus.mem_col = bus.col1;
            bus.mem_we  = bus.we1;
        end else begin
            bus.mem_row = CELL_ZERO;
            bus.mem_col = CELL_ZERO;
            bus.mem_we  = 1'b0;
        end
    end

    assign bus.mem_oe  = rd0_s | rd1_s;
    assign bus.gnt0    = gnt0_r;
    assign bus.gnt1    = gnt1_r;
    assign bus.rvalid0 = rvalid0_r;
    assign bus.rvalid1 = rvalid1_r;
    assign bus.rdata0  = rvalid0_r & bus.mem_in;
    assign bus.rdata1  = rvalid1_r & bus.mem_in;

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Directed bench for maze_mem_arbiter: one unlimited-hold instance and one max_hold=4
// instance share the same stimulus.
module tb_maze_mem_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    maze_mem_arbiter_if #(.maze_width(6)) bus ();
    maze_mem_arbiter_if #(.maze_width(6)) hb ();

    maze_mem_arbiter #(.maze_width(6), .max_hold(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    maze_mem_arbiter #(.maze_width(6), .max_hold(4)) dut_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hb)
    );

    assign hb.req0   = bus.req0;
    assign hb.req1   = bus.req1;
    assign hb.row0   = bus.row0;
    assign hb.col0   = bus.col0;
    assign hb.row1   = bus.row1;
    assign hb.col1   = bus.col1;
    assign hb.oe0    = bus.oe0;
    assign hb.we0    = bus.we0;
    assign hb.oe1    = bus.oe1;
    assign hb.we1    = bus.we1;
    assign hb.mem_in = bus.mem_in;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
        bus.row0   = 6'd0;
        bus.col0   = 6'd0;
        bus.row1   = 6'd0;
        bus.col1   = 6'd0;
        bus.oe0    = 1'b0;
        bus.we0    = 1'b0;
        bus.oe1    = 1'b0;
        bus.we1    = 1'b0;
        bus.mem_in = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clear_inputs();
        #2;

        // Reset state
        check_eq("rst_gnt0", 32'(bus.gnt0), 32'd0);
        check_eq("rst_gnt1", 32'(bus.gnt1), 32'd0);
        check_eq("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
        check_eq("rst_mem_oe", 32'(bus.mem_oe), 32'd0);
        tick();
        rst_n = 1'b1;

        // Single requester read
        bus.req0 = 1'b1;
        #1;
        check_eq("no_zero_cycle_gnt", 32'(bus.gnt0), 32'd0);
        tick();
        check_eq("t1_gnt0", 32'(bus.gnt0), 32'd1);
        bus.oe0  = 1'b1;
        bus.row0 = 6'd5;
        bus.col0 = 6'd7;
        #1;
        check_eq("t1_mem_row", 32'(bus.mem_row), 32'd5);
        check_eq("t1_mem_col", 32'(bus.mem_col), 32'd7);
        check_eq("t1_mem_oe", 32'(bus.mem_oe), 32'd1);
        check_eq("t1_mem_we", 32'(bus.mem_we), 32'd0);
        tick();
        bus.oe0    = 1'b0;
        bus.mem_in = 1'b1;
        #1;
        check_eq("t1_rvalid0", 32'(bus.rvalid0), 32'd1);
        check_eq("t1_rdata0", 32'(bus.rdata0), 32'd1);
        check_eq("t1_rvalid1", 32'(bus.rvalid1), 32'd0);
        bus.req0 = 1'b0;
        tick();
        check_eq("t1_release_gnt0", 32'(bus.gnt0), 32'd0);
        check_eq("t1_rvalid0_off", 32'(bus.rvalid0), 32'd0);
        check_eq("t1_rdata0_gated", 32'(bus.rdata0), 32'd0);

        // Tie, release, turnaround, round-robin
        apply_reset();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        tick();
        check_eq("t2_tie_gnt0", 32'(bus.gnt0), 32'd1);
        check_eq("t2_tie_gnt1", 32'(bus.gnt1), 32'd0);
        tick();
        tick();
        check_eq("t2_keep_gnt0", 32'(bus.gnt0), 32'd1);
        bus.req0 = 1'b0;
        tick();
        bus.oe1 = 1'b1;
        bus.we1 = 1'b1;
        #1;
        check_eq("t2_turn_gnt0", 32'(bus.gnt0), 32'd0);
        check_eq("t2_turn_gnt1", 32'(bus.gnt1), 32'd0);
        check_eq("t2_turn_mem_oe", 32'(bus.mem_oe), 32'd0);
        check_eq("t2_turn_mem_we", 32'(bus.mem_we), 32'd0);
        tick();
        check_eq("t2_gnt1", 32'(bus.gnt1), 32'd1);
        bus.oe1 = 1'b0;
        bus.we1 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        check_eq("t2_turn2_gnt1", 32'(bus.gnt1), 32'd0);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        tick();
        check_eq("t2_rr_gnt0", 32'(bus.gnt0), 32'd1);
        check_eq("t2_rr_gnt1", 32'(bus.gnt1), 32'd0);

        // Hold limit 4 versus unlimited
        apply_reset();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("t3_hold_gnt0", 32'(hb.gnt0), 32'd1);
        end
        tick();
        check_eq("t3_preempt_gnt0", 32'(hb.gnt0), 32'd0);
        check_eq("t3_preempt_gnt1", 32'(hb.gnt1), 32'd0);
        tick();
        check_eq("t3_new_gnt1", 32'(hb.gnt1), 32'd1);
        check_eq("t3_nolimit_gnt0", 32'(bus.gnt0), 32'd1);
        check_eq("t3_nolimit_gnt1", 32'(bus.gnt1), 32'd0);

        // Read in the final owned cycle returns during turnaround
        apply_reset();
        bus.req0 = 1'b1;
        tick();
        bus.oe0  = 1'b1;
        bus.row0 = 6'd3;
        bus.req0 = 1'b0;
        #1;
        check_eq("t4_last_mem_oe", 32'(bus.mem_oe), 32'd1);
        tick();
        bus.oe0    = 1'b0;
        bus.mem_in = 1'b1;
        #1;
        check_eq("t4_turn_gnt0", 32'(bus.gnt0), 32'd0);
        check_eq("t4_turn_rvalid0", 32'(bus.rvalid0), 32'd1);
        check_eq("t4_turn_rdata0", 32'(bus.rdata0), 32'd1);
        check_eq("t4_turn_rvalid1", 32'(bus.rvalid1), 32'd0);

        // Non-granted strobes ignored; write beats read
        apply_reset();
        bus.req0 = 1'b1;
        bus.row0 = 6'd2;
        tick();
        bus.oe1  = 1'b1;
        bus.we1  = 1'b1;
        bus.row1 = 6'd9;
        #1;
        check_eq("t5_foreign_mem_we", 32'(bus.mem_we), 32'd0);
        check_eq("t5_foreign_mem_oe", 32'(bus.mem_oe), 32'd0);
        check_eq("t5_owner_row", 32'(bus.mem_row), 32'd2);
        bus.we1 = 1'b0;
        #1;
        check_eq("t5_foreign_oe_only", 32'(bus.mem_oe), 32'd0);
        tick();
        check_eq("t5_no_rvalid1", 32'(bus.rvalid1), 32'd0);
        bus.oe1 = 1'b0;
        bus.oe0 = 1'b1;
        bus.we0 = 1'b1;
        #1;
        check_eq("t5_wr_mem_we", 32'(bus.mem_we), 32'd1);
        check_eq("t5_wr_mem_oe", 32'(bus.mem_oe), 32'd0);
        tick();
        check_eq("t5_wr_no_rvalid0", 32'(bus.rvalid0), 32'd0);

        // Asynchronous reset mid-burst with a read in flight
        apply_reset();
        bus.req1 = 1'b1;
        tick();
        bus.oe1  = 1'b1;
        bus.row1 = 6'd4;
        tick();
        check_eq("t6_pre_gnt1", 32'(bus.gnt1), 32'd1);
        check_eq("t6_pre_rvalid1", 32'(bus.rvalid1), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_gnt1", 32'(bus.gnt1), 32'd0);
        check_eq("t6_async_rvalid1", 32'(bus.rvalid1), 32'd0);
        clear_inputs();
        tick();
        rst_n    = 1'b1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        tick();
        check_eq("t6_post_gnt0", 32'(bus.gnt0), 32'd1);
        check_eq("t6_post_gnt1", 32'(bus.gnt1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
